// File: rtl/stu_upstream_collector_pkg.sv
// Shared definitions for the PE->stack upstream collector: field widths,
// cntl encodings, FSM state encodings and the buffered beat payload.
package stu_upstream_collector_pkg;

  localparam int unsigned NUM_PE = 64;
  localparam int unsigned PEID_W = 6;
  localparam int unsigned TYPE_W = 2;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned OOB_W  = 32;
  localparam int unsigned CNTL_W = 2;

  localparam logic [1:0] CNTL_MOM     = 2'b00;
  localparam logic [1:0] CNTL_SOM     = 2'b01;
  localparam logic [1:0] CNTL_EOM     = 2'b10;
  localparam logic [1:0] CNTL_SOM_EOM = 2'b11;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // One beat as held in the output FIFO.
  typedef struct packed {
    logic [CNTL_W-1:0] cntl;
    logic [TYPE_W-1:0] beat_type;
    logic [DATA_W-1:0] data;
    logic [OOB_W-1:0]  oob;
    logic [PEID_W-1:0] pe_id;
  } beat_t;

  // Next PE index with wrap at NUM_PE-1.
  function automatic logic [PEID_W-1:0] next_pe(input logic [PEID_W-1:0] id);
    if (32'(id) == NUM_PE - 1) return '0;
    return id + PEID_W'(1);
  endfunction

endpackage

// File: rtl/stu_upstream_collector_if.sv
// Upstream bus bundle: per-PE valid/ready beat inputs, serialized output
// stream toward the stack controller, and sticky per-PE framing errors.
//   slave  : the collector (receives PE beats, drives the controller stream)
//   master : the environment (PEs + stack controller)
interface stu_upstream_collector_if;
  import stu_upstream_collector_pkg::*;

  logic [NUM_PE-1:0]        pe__stu__valid;
  logic [CNTL_W*NUM_PE-1:0] pe__stu__cntl;
  logic [TYPE_W*NUM_PE-1:0] pe__stu__type;
  logic [DATA_W*NUM_PE-1:0] pe__stu__data;
  logic [OOB_W*NUM_PE-1:0]  pe__stu__oob_data;
  logic [NUM_PE-1:0]        stu__pe__ready;

  logic                     stu__cont__valid;
  logic [CNTL_W-1:0]        stu__cont__cntl;
  logic [TYPE_W-1:0]        stu__cont__type;
  logic [DATA_W-1:0]        stu__cont__data;
  logic [OOB_W-1:0]         stu__cont__oob_data;
  logic [PEID_W-1:0]        stu__cont__peId;
  logic                     cont__stu__ready;

  logic [NUM_PE-1:0]        stu__sys__protoErr;

  modport slave (
    input  pe__stu__valid, pe__stu__cntl, pe__stu__type, pe__stu__data,
           pe__stu__oob_data, cont__stu__ready,
    output stu__pe__ready, stu__cont__valid, stu__cont__cntl, stu__cont__type,
           stu__cont__data, stu__cont__oob_data, stu__cont__peId,
           stu__sys__protoErr
  );

  modport master (
    output pe__stu__valid, pe__stu__cntl, pe__stu__type, pe__stu__data,
           pe__stu__oob_data, cont__stu__ready,
    input  stu__pe__ready, stu__cont__valid, stu__cont__cntl, stu__cont__type,
           stu__cont__data, stu__cont__oob_data, stu__cont__peId,
           stu__sys__protoErr
  );

endinterface

// File: rtl/stu_rr_arbiter.sv
// Combinational round-robin pick: rotate requests so rr_ptr sits at bit 0,
// take the lowest set bit, rotate the index back.
//   req     : per-PE request vector
//   rr_ptr  : highest-priority PE index
//   gnt     : one-hot grant (zero when no request)
//   gnt_idx : encoded grant index
//   gnt_vld : any request present
module stu_rr_arbiter
  import stu_upstream_collector_pkg::*;
(
  input  logic [NUM_PE-1:0] req,
  input  logic [PEID_W-1:0] rr_ptr,
  output logic [NUM_PE-1:0] gnt,
  output logic [PEID_W-1:0] gnt_idx,
  output logic              gnt_vld
);

  logic [2*NUM_PE-1:0] req_dbl;
  logic [NUM_PE-1:0]   req_rot;
  logic [PEID_W-1:0]   first;
  logic [PEID_W:0]     sum;

  always_comb begin
    req_dbl = {req, req};
    req_rot = NUM_PE'(req_dbl >> rr_ptr);
    first   = '0;
    gnt_vld = 1'b0;
    // Descending scan so the lowest set bit is the last one written.
    for (int i = NUM_PE - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        first   = PEID_W'(i);
        gnt_vld = 1'b1;
      end
    end
    sum = {1'b0, first} + {1'b0, rr_ptr};
    if (sum >= (PEID_W+1)'(NUM_PE)) sum = sum - (PEID_W+1)'(NUM_PE);
    gnt_idx = sum[PEID_W-1:0];
    gnt     = gnt_vld ? (NUM_PE'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/stu_upstream_collector.sv
// Stack-side receiver for the PE->stack upstream bus. Arbitrates whole packets
// round-robin across all PEs, tags each beat with its source PE id and
// forwards it through a 2-entry FIFO toward the stack controller.
//   clk           : clock
//   reset_poweron : async reset, active-high
//   bus (slave)   : per-PE beat inputs / readies, controller output stream,
//                   sticky per-PE framing error flags
module stu_upstream_collector
  import stu_upstream_collector_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_poweron,
  stu_upstream_collector_if.slave  bus
);

  logic [0:0]        state_q, state_d;
  logic [PEID_W-1:0] owner_q, owner_d;
  logic [PEID_W-1:0] rr_q, rr_d;
  logic [NUM_PE-1:0] err_q, err_d;

  beat_t             mem_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q;

  logic [NUM_PE-1:0] arb_gnt;
  logic [PEID_W-1:0] arb_idx;
  logic              arb_vld;

  logic [NUM_PE-1:0] grant_oh;
  logic [PEID_W-1:0] grant_idx;
  logic              grant_vld;
  logic              space;
  logic              accept;
  logic              pop;
  beat_t             beat_in;
  beat_t             head;

  stu_rr_arbiter u_arb (
    .req     (bus.pe__stu__valid),
    .rr_ptr  (rr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  // Grant source: arbiter when idle, the packet owner while locked.
  always_comb begin
    grant_oh  = arb_gnt;
    grant_idx = arb_idx;
    grant_vld = arb_vld;
    if (state_q == ST_LOCKED) begin
      grant_oh  = NUM_PE'(1) << owner_q;
      grant_idx = owner_q;
      grant_vld = 1'b1;
    end
  end

  // Space comes from the registered count only; reset also forces readies low.
  assign space  = (count_q != 2'd2) && !reset_poweron;
  assign accept = space && grant_vld && bus.pe__stu__valid[grant_idx];
  assign pop    = (count_q != 2'd0) && bus.cont__stu__ready;

  assign bus.stu__pe__ready = space ? grant_oh : '0;

  // Mux the granted PE's beat.
  always_comb begin
    beat_in.cntl      = bus.pe__stu__cntl[32'(grant_idx)*CNTL_W +: CNTL_W];
    beat_in.beat_type = bus.pe__stu__type[32'(grant_idx)*TYPE_W +: TYPE_W];
    beat_in.data      = bus.pe__stu__data[32'(grant_idx)*DATA_W +: DATA_W];
    beat_in.oob       = bus.pe__stu__oob_data[32'(grant_idx)*OOB_W +: OOB_W];
    beat_in.pe_id     = grant_idx;
  end

  // Packet lock FSM, rr pointer update and framing-error detection.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    err_d   = err_q;
    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (beat_in.cntl == CNTL_MOM || beat_in.cntl == CNTL_EOM)
            err_d[grant_idx] = 1'b1;
          // A stray MOM opens a packet just like SOM; a stray EOM acts as SOM_EOM.
          if (beat_in.cntl == CNTL_SOM || beat_in.cntl == CNTL_MOM) begin
            state_d = ST_LOCKED;
            owner_d = grant_idx;
          end else begin
            rr_d = next_pe(grant_idx);
          end
        end
        ST_LOCKED: begin
          if (beat_in.cntl == CNTL_SOM || beat_in.cntl == CNTL_SOM_EOM)
            err_d[owner_q] = 1'b1;
          if (beat_in.cntl == CNTL_EOM || beat_in.cntl == CNTL_SOM_EOM) begin
            state_d = ST_IDLE;
            rr_d    = next_pe(owner_q);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end
  end

  // 2-entry output FIFO; push and pop may both happen in one cycle.
  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (accept) begin
        mem_q[wr_ptr_q] <= beat_in;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({accept, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head = mem_q[rd_ptr_q];

  assign bus.stu__cont__valid    = (count_q != 2'd0);
  assign bus.stu__cont__cntl     = head.cntl;
  assign bus.stu__cont__type     = head.beat_type;
  assign bus.stu__cont__data     = head.data;
  assign bus.stu__cont__oob_data = head.oob;
  assign bus.stu__cont__peId     = head.pe_id;
  assign bus.stu__sys__protoErr  = err_q;

endmodule

// File: tb/tb_stu_upstream_collector.sv
// Directed bench for stu_upstream_collector: single beats, packet atomicity,
// downstream stall, rr wrap, framing errors and mid-packet reset.
module tb_stu_upstream_collector;
  import stu_upstream_collector_pkg::*;

  logic clk;
  logic reset_poweron;
  int   checks;
  int   failures;
  int   s_idx;
  int   r_idx;

  stu_upstream_collector_if bus();

  stu_upstream_collector dut (
    .clk           (clk),
    .reset_poweron (reset_poweron),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pe(input int i, input logic [1:0] c, input logic [31:0] d);
    bus.pe__stu__valid[i]              = 1'b1;
    bus.pe__stu__cntl[i*2 +: 2]        = c;
    bus.pe__stu__type[i*2 +: 2]        = 2'b01;
    bus.pe__stu__data[i*32 +: 32]      = d;
    bus.pe__stu__oob_data[i*32 +: 32]  = ~d;
  endtask

  task automatic clr_pe(input int i);
    bus.pe__stu__valid[i] = 1'b0;
  endtask

  function automatic logic [1:0] t3_cntl(input int k);
    if (k == 0) return CNTL_SOM;
    if (k == 5) return CNTL_EOM;
    return CNTL_MOM;
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    reset_poweron         = 1'b1;
    bus.pe__stu__valid    = '0;
    bus.pe__stu__cntl     = '0;
    bus.pe__stu__type     = '0;
    bus.pe__stu__data     = '0;
    bus.pe__stu__oob_data = '0;
    bus.cont__stu__ready  = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_valid",    64'(bus.stu__cont__valid), 64'd0);
    chk("rst_ready",    bus.stu__pe__ready, 64'd0);
    chk("rst_protoerr", bus.stu__sys__protoErr, 64'd0);
    chk("rst_data",     64'(bus.stu__cont__data), 64'd0);
    chk("rst_peid",     64'(bus.stu__cont__peId), 64'd0);
    reset_poweron = 1'b0;
    tick();

    // 1: PE5 single-beat packet
    set_pe(5, CNTL_SOM_EOM, 32'hA5);
    #2;
    chk("t1_ready", bus.stu__pe__ready, 64'(1) << 5);
    tick();
    clr_pe(5);
    #2;
    chk("t1_valid", 64'(bus.stu__cont__valid), 64'd1);
    chk("t1_peid",  64'(bus.stu__cont__peId), 64'd5);
    chk("t1_cntl",  64'(bus.stu__cont__cntl), 64'd3);
    chk("t1_data",  64'(bus.stu__cont__data), 64'hA5);
    chk("t1_oob",   64'(bus.stu__cont__oob_data), 64'hFFFF_FF5A);
    chk("t1_type",  64'(bus.stu__cont__type), 64'd1);
    tick();
    chk("t1_drained", 64'(bus.stu__cont__valid), 64'd0);

    // 2: rr_ptr back to 0, PE3 three-beat packet vs PE7 single beat
    reset_poweron = 1'b1;
    tick();
    reset_poweron = 1'b0;
    set_pe(3, CNTL_SOM, 32'h30);
    set_pe(7, CNTL_SOM_EOM, 32'h70);
    #2;
    chk("t2_ready_som", bus.stu__pe__ready, 64'(1) << 3);
    tick();
    set_pe(3, CNTL_MOM, 32'h31);
    #2;
    chk("t2_ready_mom", bus.stu__pe__ready, 64'(1) << 3);
    chk("t2_out0_data", 64'(bus.stu__cont__data), 64'h30);
    chk("t2_out0_cntl", 64'(bus.stu__cont__cntl), 64'(CNTL_SOM));
    chk("t2_out0_peid", 64'(bus.stu__cont__peId), 64'd3);
    tick();
    set_pe(3, CNTL_EOM, 32'h32);
    #2;
    chk("t2_ready_eom", bus.stu__pe__ready, 64'(1) << 3);
    chk("t2_out1_data", 64'(bus.stu__cont__data), 64'h31);
    tick();
    clr_pe(3);
    #2;
    chk("t2_ready_pe7", bus.stu__pe__ready, 64'(1) << 7);
    chk("t2_out2_data", 64'(bus.stu__cont__data), 64'h32);
    chk("t2_out2_cntl", 64'(bus.stu__cont__cntl), 64'(CNTL_EOM));
    tick();
    clr_pe(7);
    #2;
    chk("t2_out3_data", 64'(bus.stu__cont__data), 64'h70);
    chk("t2_out3_peid", 64'(bus.stu__cont__peId), 64'd7);
    tick();
    chk("t2_drained", 64'(bus.stu__cont__valid), 64'd0);

    // 3: PE9 six-beat packet with a 10-cycle downstream stall
    s_idx = 0;
    r_idx = 0;
    for (int cyc = 0; cyc < 60 && r_idx < 6; cyc++) begin
      bus.cont__stu__ready = !(cyc >= 2 && cyc < 12);
      if (s_idx < 6) set_pe(9, t3_cntl(s_idx), 32'(32'h90 + s_idx));
      else clr_pe(9);
      #2;
      if (cyc == 8) begin
        chk("t3_stall_ready", bus.stu__pe__ready, 64'd0);
        chk("t3_buffered",    64'(s_idx - r_idx), 64'd2);
        chk("t3_stall_valid", 64'(bus.stu__cont__valid), 64'd1);
      end
      if (bus.stu__pe__ready[9] && s_idx < 6) s_idx++;
      if (bus.stu__cont__valid && bus.cont__stu__ready) begin
        chk("t3_data", 64'(bus.stu__cont__data), 64'(32'h90 + r_idx));
        chk("t3_cntl", 64'(bus.stu__cont__cntl), 64'(t3_cntl(r_idx)));
        chk("t3_peid", 64'(bus.stu__cont__peId), 64'd9);
        r_idx++;
      end
      tick();
    end
    clr_pe(9);
    bus.cont__stu__ready = 1'b1;
    chk("t3_all_received", 64'(r_idx), 64'd6);
    chk("t3_drained", 64'(bus.stu__cont__valid), 64'd0);

    // 4: move rr_ptr to 63 via PE62, then PE63 and PE0 compete
    set_pe(62, CNTL_SOM_EOM, 32'h62);
    #2;
    chk("t4_ready_pe62", bus.stu__pe__ready, 64'(1) << 62);
    tick();
    clr_pe(62);
    tick();
    set_pe(63, CNTL_SOM_EOM, 32'h63);
    set_pe(0, CNTL_SOM_EOM, 32'h00);
    #2;
    chk("t4_ready_pe63", bus.stu__pe__ready, 64'(1) << 63);
    tick();
    clr_pe(63);
    #2;
    chk("t4_ready_pe0", bus.stu__pe__ready, 64'd1);
    chk("t4_out_pe63",  64'(bus.stu__cont__peId), 64'd63);
    tick();
    clr_pe(0);
    #2;
    chk("t4_out_pe0",   64'(bus.stu__cont__peId), 64'd0);
    chk("t4_out_valid", 64'(bus.stu__cont__valid), 64'd1);
    tick();

    // 5: PE2 opens with MOM while idle
    set_pe(2, CNTL_MOM, 32'h22);
    #2;
    chk("t5_ready", bus.stu__pe__ready, 64'(1) << 2);
    tick();
    set_pe(2, CNTL_EOM, 32'h23);
    #2;
    chk("t5_protoerr",  bus.stu__sys__protoErr, 64'(1) << 2);
    chk("t5_out_cntl",  64'(bus.stu__cont__cntl), 64'(CNTL_MOM));
    chk("t5_out_data",  64'(bus.stu__cont__data), 64'h22);
    chk("t5_out_peid",  64'(bus.stu__cont__peId), 64'd2);
    chk("t5_locked",    bus.stu__pe__ready, 64'(1) << 2);
    tick();
    clr_pe(2);
    #2;
    chk("t5_out_eom",      64'(bus.stu__cont__data), 64'h23);
    chk("t5_protoerr_hold", bus.stu__sys__protoErr, 64'(1) << 2);
    tick();

    // 6: reset in the middle of a PE4 packet
    set_pe(4, CNTL_SOM, 32'h40);
    tick();
    set_pe(4, CNTL_MOM, 32'h41);
    #2;
    reset_poweron = 1'b1;
    #1;
    chk("t6_valid",    64'(bus.stu__cont__valid), 64'd0);
    chk("t6_data",     64'(bus.stu__cont__data), 64'd0);
    chk("t6_peid",     64'(bus.stu__cont__peId), 64'd0);
    chk("t6_ready",    bus.stu__pe__ready, 64'd0);
    chk("t6_protoerr", bus.stu__sys__protoErr, 64'd0);
    tick();
    set_pe(1, CNTL_SOM_EOM, 32'h11);
    reset_poweron = 1'b0;
    #2;
    chk("t6_ready_pe1", bus.stu__pe__ready, 64'(1) << 1);
    tick();
    clr_pe(1);
    #2;
    chk("t6_out_valid", 64'(bus.stu__cont__valid), 64'd1);
    chk("t6_out_peid",  64'(bus.stu__cont__peId), 64'd1);
    chk("t6_out_data",  64'(bus.stu__cont__data), 64'h11);
    chk("t6_ready_pe4", bus.stu__pe__ready, 64'(1) << 4);
    tick();
    clr_pe(4);
    #2;
    chk("t6_protoerr_pe4", bus.stu__sys__protoErr, 64'(1) << 4);
    chk("t6_out_pe4",      64'(bus.stu__cont__peId), 64'd4);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
